// File: rtl/riscv_pkg.sv
// Shared core-level definitions: word size, canonical NOP, PC step and the
// {pc, instr} record carried through the fetch prefetch buffer.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Instruction fetch is word addressed; low address bits are never honoured.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; flush and reset both empty it and take
// priority over a same-cycle push or pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full && !flush;
    assign w_pop_ok  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok && !reset) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: sequential PC generation, credit-limited imem requests,
// prefetch buffering and redirect with discard of stale in-flight responses.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0]  r_fetch_pc;
    logic [XLEN-1:0]  r_rsp_pc;
    logic [CNT_W-1:0] r_inflight;
    logic [CNT_W-1:0] r_drop;

    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_entry;
    logic [CNT_W:0]   w_credit_sum;
    logic             w_req_fire;
    logic             w_rsp_legal;
    logic             w_rsp_live;
    logic             w_out_fire;
    logic [CNT_W-1:0] w_fire_inc;
    logic [CNT_W-1:0] w_rsp_dec;
    logic [XLEN-1:0]  w_redirect_pc;

    // Outstanding requests plus buffered entries never exceed the FIFO depth,
    // so every live response is guaranteed a free slot.
    assign w_credit_sum   = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign imem_req_valid = !reset && !redirect_valid && !w_fifo_full
                            && (w_credit_sum < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp_legal    = imem_rsp_valid && (r_inflight != '0);
    assign w_rsp_live     = w_rsp_legal && (r_drop == '0);
    assign w_fire_inc     = {{(CNT_W-1){1'b0}}, w_req_fire};
    assign w_rsp_dec      = {{(CNT_W-1){1'b0}}, w_rsp_legal};
    assign w_redirect_pc  = align_pc(redirect_pc);

    assign w_push_entry   = '{pc: r_rsp_pc, instr: imem_rsp_data};
    assign w_out_fire     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old path.
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            r_inflight <= r_inflight - w_rsp_dec;
            r_drop     <= r_inflight - w_rsp_dec;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            if (w_rsp_live) begin
                r_rsp_pc <= r_rsp_pc + PC_STEP;
            end
            r_inflight <= r_inflight + w_fire_inc - w_rsp_dec;
            if (w_rsp_legal && (r_drop != '0)) begin
                r_drop <= r_drop - CNT_W'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_rsp_live && !redirect_valid),
        .push_data (w_push_entry),
        .pop       (w_out_fire),
        .flush     (redirect_valid),
        .pop_data  (w_head),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

    assign out_valid       = !w_fifo_empty;
    assign out_pc          = w_fifo_empty ? '0 : w_head.pc;
    assign out_instruction = w_fifo_empty ? NOP_INSTR : w_head.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a 1-cycle imem model with an optional
// response hold, plus an in-order scoreboard on every decode handshake.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc   = 32'h0;
    logic        rsp_en   = 1'b1;
    logic [31:0] pend_q [$];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5670;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: scoreboard the decode handshake, let the edge happen, then
    // play the memory side (accepted requests answer one cycle later).
    task automatic step();
        logic        acc;
        logic [31:0] acc_addr;
        #1;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        if (out_valid && out_ready && !redirect_valid && !reset) begin
            check("out_pc", out_pc, exp_pc);
            check("out_instr", out_instruction, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        if (reset) begin
            pend_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else begin
            if (acc) pend_q.push_back(acc_addr);
            if (rsp_en && pend_q.size() > 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
        end
        #1;
    endtask

    task automatic run_until(input logic [31:0] target, input string tag);
        int cyc = 0;
        while (exp_pc != target && cyc < 60) begin
            step();
            cyc++;
        end
        check(tag, exp_pc, target);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset  = 1'b0;
        exp_pc = 32'h0;
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;

        // Reset state
        step();
        step();
        check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instruction, 32'h0000_0013);

        // Streaming
        reset = 1'b0;
        #1;
        check("s_req0_valid", {31'h0, imem_req_valid}, 32'h1);
        check("s_req0_addr", imem_req_addr, 32'h0);
        check("s_post_rst_instr", out_instruction, 32'h0000_0013);
        step();
        check("s_req1_addr", imem_req_addr, 32'h4);
        check("s_no_early_valid", {31'h0, out_valid}, 32'h0);
        step();
        check("s_first_valid", {31'h0, out_valid}, 32'h1);
        check("s_first_pc", out_pc, 32'h0);
        check("s_credit_full", {31'h0, imem_req_valid}, 32'h0);
        run_until(32'h10, "s_drain");

        // Backpressure
        out_ready = 1'b0;
        do_reset();
        repeat (5) step();
        check("bp_req_blocked", {31'h0, imem_req_valid}, 32'h0);
        check("bp_head_pc", out_pc, 32'h0);
        repeat (3) step();
        check("bp_still_blocked", {31'h0, imem_req_valid}, 32'h0);
        check("bp_head_stable", out_pc, 32'h0);
        check("bp_next_addr", imem_req_addr, 32'h8);
        out_ready = 1'b1;
        #1;
        step();
        check("bp_resume_valid", {31'h0, imem_req_valid}, 32'h1);
        check("bp_resume_addr", imem_req_addr, 32'h8);

        // Flush with two requests in flight (responses held back)
        rsp_en = 1'b0;
        step();
        step();
        check("fl_two_inflight", {31'h0, imem_req_valid}, 32'h0);
        check("fl_fifo_empty", {31'h0, out_valid}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        rsp_en         = 1'b1;
        #1;
        check("fl_no_req_redirect", {31'h0, imem_req_valid}, 32'h0);
        step();
        redirect_valid = 1'b0;
        exp_pc         = 32'h100;
        #1;
        check("fl_drop1_no_out", {31'h0, out_valid}, 32'h0);
        step();
        check("fl_new_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("fl_new_req_addr", imem_req_addr, 32'h100);
        check("fl_drop2_no_out", {31'h0, out_valid}, 32'h0);
        step();
        check("fl_drop_done_no_out", {31'h0, out_valid}, 32'h0);
        run_until(32'h108, "fl_drain");

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        #1;
        check("mis_no_req", {31'h0, imem_req_valid}, 32'h0);
        step();
        redirect_valid = 1'b0;
        exp_pc         = 32'h100;
        #1;
        check("mis_aligned_addr", imem_req_addr, 32'h100);
        run_until(32'h108, "mis_drain");

        // Collision: redirect, pop and live response in one cycle
        do_reset();
        step();
        step();
        check("col_head_valid", {31'h0, out_valid}, 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        step();
        redirect_valid = 1'b0;
        exp_pc         = 32'h200;
        #1;
        check("col_out_valid", {31'h0, out_valid}, 32'h0);
        check("col_out_instr", out_instruction, 32'h0000_0013);
        check("col_out_pc", out_pc, 32'h0);
        check("col_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("col_req_addr", imem_req_addr, 32'h200);
        run_until(32'h208, "col_drain");

        // Address wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        step();
        redirect_valid = 1'b0;
        exp_pc         = 32'hFFFF_FFFC;
        #1;
        check("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        run_until(32'h4, "wrap_drain");

        // Reset mid-stream
        reset = 1'b1;
        step();
        check("mr_out_valid", {31'h0, out_valid}, 32'h0);
        check("mr_out_instr", out_instruction, 32'h0000_0013);
        check("mr_req_valid", {31'h0, imem_req_valid}, 32'h0);
        reset  = 1'b0;
        exp_pc = 32'h0;
        #1;
        check("mr_first_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("mr_first_req_addr", imem_req_addr, 32'h0);
        run_until(32'h8, "mr_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
